// File: rtl/seg_scan_counter.sv
// Up/down BCD counter with tick divider, multiplexed 7-segment scan,
// brightness PWM and leading-zero blanking, all driven directly from clk.
module seg_scan_counter #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50000000,
   parameter int SCAN_DIV = 80000,
   parameter int PWM_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  up,
   input  logic                  clear,
   input  logic [PWM_BITS-1:0]   light,
   input  logic                  blank_lz,
   output logic [6:0]            num,
   output logic [DIGITS-1:0]     en,
   output logic [4*DIGITS-1:0]   value,
   output logic                  wrap
);

   localparam int TCNT_W = $clog2(TICK_DIV);
   localparam int SCNT_W = $clog2(SCAN_DIV);
   localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [TCNT_W-1:0]   tcnt;
   logic                tick;
   logic [SCNT_W-1:0]   scnt;
   logic [SLOT_W-1:0]   slot;
   logic [PWM_BITS-1:0] p;

   logic [4*DIGITS-1:0] value_step;
   logic                step_carry;
   logic [3:0]          step_digit;
   logic [3:0]          cur_digit;
   logic [SLOT_W-1:0]   top_nz;
   logic                blanked;
   logic                lit;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   assign tick = (tcnt == TCNT_W'(TICK_DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (clear || tick) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Ripple the +1/-1 through the digits; a carry out of the top digit is a wrap.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      value_step = value;
      step_carry = 1'b1;
      step_digit = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         step_digit = value[4*k +: 4];
         if (step_carry) begin
            if (up) begin
               if (step_digit == 4'd9) begin
                  step_digit = 4'd0;
               end else begin
                  step_digit = step_digit + 4'd1;
                  step_carry = 1'b0;
               end
            end else begin
               if (step_digit == 4'd0) begin
                  step_digit = 4'd9;
               end else begin
                  step_digit = step_digit - 4'd1;
                  step_carry = 1'b0;
               end
            end
         end
         value_step[4*k +: 4] = step_digit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clear) begin
            value <= '0;
         end else if (tick && run) begin
            value <= value_step;
            wrap  <= step_carry;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt <= '0;
         slot <= '0;
         p    <= '0;
      end else begin
         p <= p + 1'b1;
         if (scnt == SCNT_W'(SCAN_DIV - 1)) begin
            scnt <= '0;
            slot <= (slot == SLOT_W'(DIGITS - 1)) ? '0 : slot + 1'b1;
         end else begin
            scnt <= scnt + 1'b1;
         end
      end
   end

   // Digit under the scan slot, and the highest nonzero digit for blanking.
   always_comb begin
      cur_digit = 4'd0;
      top_nz    = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (slot == SLOT_W'(k)) cur_digit = value[4*k +: 4];
         if (value[4*k +: 4] != 4'd0) top_nz = SLOT_W'(k);
      end
   end

   assign blanked = blank_lz && (slot > top_nz);
   assign lit     = (p <= light) && !blanked;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num <= 7'h7F;
         en  <= '1;
      end else if (lit) begin
         num <= seg7(cur_digit);
         en  <= ~(DIGITS'(1) << slot);
      end else begin
         num <= 7'h7F;
         en  <= '1;
      end
   end

endmodule

// File: tb/tb_seg_scan_counter.sv
// Directed bench for seg_scan_counter: decimal reference model feeds a
// scoreboard queue each cycle, compared against the DUT after the edge.
module tb_seg_scan_counter;

   localparam int DIGITS   = 4;
   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 8;
   localparam int PWM_BITS = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        up;
   logic        clear;
   logic [1:0]  light;
   logic        blank_lz;
   logic [6:0]  num;
   logic [3:0]  en;
   logic [15:0] value;
   logic        wrap;

   typedef struct {
      logic [15:0] value;
      logic        wrap;
      logic [3:0]  en;
      logic [6:0]  num;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad   = 0;
   int wrap_seen = 0;

   int m_val, m_tcnt, m_scnt, m_slot, m_p;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int pow10 [4] = '{1, 10, 100, 1000};

   seg_scan_counter #(
      .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .PWM_BITS(PWM_BITS)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .up(up), .clear(clear),
      .light(light), .blank_lz(blank_lz),
      .num(num), .en(en), .value(value), .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / pow10[k]) % 10);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_val = 0; m_tcnt = 0; m_scnt = 0; m_slot = 0; m_p = 0;
      sb.delete();
   endtask

   // One clock: predict, push, advance, pop and compare.
   task automatic cyc(input int n);
      exp_t e, got;
      int   dig, hi;
      bit   tk, lit;
      for (int i = 0; i < n; i++) begin
         dig = (m_val / pow10[m_slot]) % 10;
         hi  = 0;
         for (int k = 0; k < 4; k++) if (((m_val / pow10[k]) % 10) != 0) hi = k;
         lit = (m_p <= int'(light)) && !(blank_lz && (m_slot > hi));
         e.en  = lit ? (4'hF & ~(4'b1 << m_slot)) : 4'hF;
         e.num = lit ? seg_tab[dig] : 7'h7F;
         e.wrap = 1'b0;
         tk = (m_tcnt == TICK_DIV - 1);
         if (clear) begin
            m_val  = 0;
            m_tcnt = 0;
         end else begin
            m_tcnt = (m_tcnt + 1) % TICK_DIV;
            if (tk && run) begin
               if (up) begin
                  if (m_val == 9999) begin m_val = 0; e.wrap = 1'b1; end
                  else m_val = m_val + 1;
               end else begin
                  if (m_val == 0) begin m_val = 9999; e.wrap = 1'b1; end
                  else m_val = m_val - 1;
               end
            end
         end
         e.value = to_bcd(m_val);
         if (m_scnt == SCAN_DIV - 1) m_slot = (m_slot + 1) % DIGITS;
         m_scnt = (m_scnt + 1) % SCAN_DIV;
         m_p    = (m_p + 1) % (1 << PWM_BITS);
         sb.push_back(e);

         @(posedge clk);
         @(negedge clk);

         got = sb.pop_front();
         check("value", 32'(value), 32'(got.value));
         check("wrap",  32'(wrap),  32'(got.wrap));
         check("en",    32'(en),    32'(got.en));
         check("num",   32'(num),   32'(got.num));
         check("en_onecold", 32'($countones(~en) <= 1), 32'd1);
         if (wrap === 1'b1) wrap_seen++;
      end
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; up = 1'b1; clear = 1'b0; light = 2'd3; blank_lz = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_value", 32'(value), 32'h0);
      check("rst_en",    32'(en),    32'hF);
      check("rst_num",   32'(num),   32'h7F);
      check("rst_wrap",  32'(wrap),  32'h0);
      rst = 1'b0;
      model_reset();

      // Count 0 -> 9999, then wrap up
      run = 1'b1; up = 1'b1;
      cyc(9999 * TICK_DIV);
      check("up_9999",      32'(value), 32'h9999);
      check("no_wrap_yet",  32'(wrap_seen), 32'd0);
      cyc(TICK_DIV);
      check("up_wrap_val",  32'(value), 32'h0);
      check("up_wrap_once", 32'(wrap_seen), 32'd1);

      // Down wrap
      up = 1'b0;
      cyc(TICK_DIV);
      check("dn_wrap_val",  32'(value), 32'h9999);
      check("dn_wrap_once", 32'(wrap_seen), 32'd2);
      cyc(TICK_DIV);
      check("dn_9998",      32'(value), 32'h9998);

      // Hold
      run = 1'b0;
      cyc(40);
      check("hold", 32'(value), 32'h9998);

      // Clear on a tick cycle
      run = 1'b1; up = 1'b1;
      for (int g = 0; g < TICK_DIV && m_tcnt != TICK_DIV - 1; g++) cyc(1);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      check("clear_val",  32'(value), 32'h0);
      check("clear_nowrap", 32'(wrap_seen), 32'd2);
      cyc(TICK_DIV - 1);
      check("clear_no_early_tick", 32'(value), 32'h0);
      cyc(1);
      check("clear_next_tick", 32'(value), 32'h1);

      // Scan and PWM at 1234
      cyc(1233 * TICK_DIV);
      run = 1'b0;
      check("at_1234", 32'(value), 32'h1234);
      light = 2'd3;
      cyc(40);
      light = 2'd0;
      cyc(32);
      light = 2'd3;

      // Leading-zero blanking at 0042 and 0
      blank_lz = 1'b1;
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      run = 1'b1;
      cyc(42 * TICK_DIV);
      run = 1'b0;
      check("at_0042", 32'(value), 32'h0042);
      cyc(40);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      cyc(40);

      // Async reset mid-count at 0517
      blank_lz = 1'b0;
      run = 1'b1;
      cyc(517 * TICK_DIV);
      check("at_0517", 32'(value), 32'h0517);
      #2 rst = 1'b1;
      #1;
      check("async_rst_value", 32'(value), 32'h0);
      check("async_rst_en",    32'(en),    32'hF);
      check("async_rst_num",   32'(num),   32'h7F);
      check("async_rst_wrap",  32'(wrap),  32'h0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cyc(2 * TICK_DIV);
      check("after_rst_count", 32'(value), 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_counter.md
Name: seg_scan_counter

Overview:
- Parametrised successor to the fixed 4-digit seconds counter/scan display path.
- Combines in one block:
  - the count-tick divider;
  - an up/down BCD counter with DIGITS digits;
  - the digit-scan divider and multiplexer;
  - brightness PWM;
  - leading-zero blanking.
- Drives the board's 7-segment pins directly from clk. Replaces the separate divider, counter and enable blocks under the board top.

Parameters:
- DIGITS, 4, number of BCD digits and of digit enables (1..8).
- TICK_DIV, 50000000, clk cycles per count tick (>=2).
- SCAN_DIV, 80000, clk cycles per digit scan slot (>=2).
- PWM_BITS, 2, width of the brightness input.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- run  input  1  1 = counter advances on ticks; 0 = hold.
- up  input  1  1 = count up, 0 = count down; sampled on the tick cycle.
- clear  input  1  synchronous clear of counter and tick divider.
- light  input  PWM_BITS  brightness level.
- blank_lz  input  1  1 = blank leading zero digits.
- num  output  7  segments, active-low; num[0]=a ... num[6]=g.
- en  output  DIGITS  digit enables, active-low; en[0] = least significant digit.
- value  output  4*DIGITS  current BCD count; digit k at [4k+3:4k].
- wrap  output  1  one-cycle pulse on counter wrap.

Behaviour:
- Reset (async, rst=1), all registered:
  - value=0, wrap=0, num=7'h7F, en=all 1s;
  - tick, scan and PWM counters = 0, slot index = 0.
- Tick divider:
  - tcnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is asserted for the single cycle with tcnt==TICK_DIV-1.
  - The divider is free-running regardless of run.
- Counter priority per cycle: clear > (tick & run) > hold.
- clear:
  - value=0 and tcnt=0 on the next edge;
  - no wrap pulse;
  - a coincident tick is discarded.
- Up step:
  - digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - All digits at 9 → all 0, and wrap=1 for one cycle.
- Down step:
  - digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - All digits at 0 → all 9, and wrap=1 for one cycle.
- value and wrap update on the edge that consumes the tick. wrap is 0 in every other cycle.
- Scan:
  - scnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the slot index advances 0→1→...→DIGITS-1→0.
- PWM:
  - A free-running PWM_BITS counter p increments every cycle.
  - The selected digit is lit when p <= light.
  - light = all 1s gives 100% duty; light=0 gives a 1/2^PWM_BITS duty.
- Leading-zero blank:
  - Applies when blank_lz=1 and the slot digit index k > index of the highest nonzero digit.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Output register, one cycle of latency from slot/p/value:
  - Lit: en = all 1s except en[slot]=0; num = pattern of value digit[slot].
  - Dark (PWM off or blanked): en=all 1s, num=7'h7F.
- Segment patterns {g..a}, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Never drive more than one en bit low in the same cycle.
- rst mid-operation forces all reset values immediately, independent of clk.

Test Plan (DIGITS=4, TICK_DIV=4, SCAN_DIV=8, PWM_BITS=2):
- Reset/run 0→9999:
  - rst pulse → value=0, en=4'hF, num=7'h7F.
  - run=1, up=1, 9999 ticks → value=16'h9999, wrap never high.
  - One more tick → value=0, wrap high exactly 1 cycle.
- Down wrap: from value=0, run=1, up=0, one tick → value=16'h9999, wrap pulse. Next tick → 16'h9998.
- Hold/clear:
  - run=0 for 40 cycles → value unchanged.
  - clear asserted on a tick cycle → value=0 next edge, no wrap, following tick 4 cycles later.
- Scan/PWM:
  - value=16'h1234, light=3 → en cycles E,D,B,7 every 8 cycles; num patterns 19,30,24,79 in step.
  - light=0 → en low only 1 of every 4 cycles within each slot.
- Blanking, blank_lz=1:
  - value=16'h0042 → slots 2,3 give en=F, num=7F; slots 0,1 show 2,4.
  - value=0 → only digit 0 lit showing 40.
- Async reset mid-count: rst asserted between clk edges at value=0x0517 → value=0 and en=F before the next edge.
